// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet-RAM write arbiter.
package pkt_arb_pkg;

  localparam int unsigned DATA_W_DEF      = 134;
  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;
  localparam int unsigned WDOG_W          = 16;
  localparam int unsigned DBG_CNT_W       = 16;

  localparam logic [1:0] TAG_TAIL = 2'b10;

  // Encoding doubles as the one-hot grant vector (LOCK0 -> 01, LOCK1 -> 10).
  typedef enum logic [1:0] {
    ARB_IDLE_S  = 2'd0,
    ARB_LOCK0_S = 2'd1,
    ARB_LOCK1_S = 2'd2
  } arb_state_e;

  // True when the word tag marks the last word of a packet.
  function automatic logic is_tail(input logic [1:0] tag);
    return tag == TAG_TAIL;
  endfunction

endpackage

// File: rtl/pkt_arb_watchdog.sv
// Lock watchdog: counts write-free cycles while a packet lock is held and
// flags a forced release once TIMEOUT_CYC of them have elapsed.
module pkt_arb_watchdog
  import pkt_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic locked_i,
  input  logic wr_i,
  output logic expire_c_o,
  output logic timeout_o
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;
  logic              timeout_q;

  // Release fires on the TIMEOUT_CYC-th idle cycle; a write that cycle wins.
  assign expire_c_o = locked_i & ~wr_i & (cnt_q >= LIMIT);

  // Next count: cleared outside a lock, on a write or on release; saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (!locked_i || wr_i || expire_c_o) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Counter and one-cycle timeout pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire_c_o;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pkt_ram_write_arbiter.sv
// Per-packet round-robin arbiter sharing one packet-buffer RAM write port
// between two word-level wr/ack writers, with a stalled-lock watchdog.
// Optional build macro PKT_RAM_WR_ARB_DEBUG_EN adds per-port packet counters.
module pkt_ram_write_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr0,
  input  logic [DATA_W-1:0] iv_wdata0,
  input  logic [ADDR_W-1:0] iv_waddr0,
  output logic              o_wdata_ack0,
  input  logic              i_wr1,
  input  logic [DATA_W-1:0] iv_wdata1,
  input  logic [ADDR_W-1:0] iv_waddr1,
  output logic              o_wdata_ack1,
  output logic              o_ram_wr,
  output logic [DATA_W-1:0] ov_ram_wdata,
  output logic [ADDR_W-1:0] ov_ram_waddr,
  output logic [1:0]        ov_grant,
  output logic              o_lock_timeout,
  output logic [15:0]       ov_debug_pkt_cnt0,
  output logic [15:0]       ov_debug_pkt_cnt1
);

  arb_state_e        state_q;
  logic              rr_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              ram_wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] waddr_q;

  logic              req0_c;
  logic              req1_c;
  logic              wr_c;
  logic              sel_c;
  logic              tail_c;
  logic              locked_c;
  logic              expire_c;
  logic [DATA_W-1:0] wdata_sel_c;
  logic [ADDR_W-1:0] waddr_sel_c;

  // A requester still holds its acked word during the ack cycle; mask it.
  assign req0_c   = i_wr0 & ~ack0_q;
  assign req1_c   = i_wr1 & ~ack1_q;
  assign locked_c = (state_q != ARB_IDLE_S);

  // Pick which port (if any) writes this cycle.
  always_comb begin
    wr_c  = 1'b0;
    sel_c = 1'b0;
    case (state_q)
      ARB_IDLE_S: begin
        if (req0_c && req1_c) begin
          wr_c  = 1'b1;
          sel_c = rr_q;
        end else if (req0_c) begin
          wr_c  = 1'b1;
          sel_c = 1'b0;
        end else if (req1_c) begin
          wr_c  = 1'b1;
          sel_c = 1'b1;
        end
      end
      ARB_LOCK0_S: begin
        wr_c  = req0_c;
        sel_c = 1'b0;
      end
      ARB_LOCK1_S: begin
        wr_c  = req1_c;
        sel_c = 1'b1;
      end
      default: begin
        wr_c  = 1'b0;
        sel_c = 1'b0;
      end
    endcase
  end

  assign wdata_sel_c = sel_c ? iv_wdata1 : iv_wdata0;
  assign waddr_sel_c = sel_c ? iv_waddr1 : iv_waddr0;
  assign tail_c      = is_tail(wdata_sel_c[DATA_W-1 -: 2]);

  pkt_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .locked_i   (locked_c),
    .wr_i       (wr_c),
    .expire_c_o (expire_c),
    .timeout_o  (o_lock_timeout)
  );

  // Arbitration FSM plus registered RAM write / ack outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ARB_IDLE_S;
      rr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ram_wr_q <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      ram_wr_q <= wr_c;
      ack0_q   <= wr_c & ~sel_c;
      ack1_q   <= wr_c & sel_c;
      if (wr_c) begin
        wdata_q <= wdata_sel_c;
        waddr_q <= waddr_sel_c;
      end
      case (state_q)
        ARB_IDLE_S: begin
          if (wr_c) begin
            if (tail_c) begin
              rr_q <= ~sel_c;
            end else begin
              state_q <= sel_c ? ARB_LOCK1_S : ARB_LOCK0_S;
            end
          end
        end
        ARB_LOCK0_S, ARB_LOCK1_S: begin
          if ((wr_c && tail_c) || expire_c) begin
            state_q <= ARB_IDLE_S;
            rr_q    <= ~sel_c;
          end
        end
        default: state_q <= ARB_IDLE_S;
      endcase
    end
  end

  assign o_wdata_ack0 = ack0_q;
  assign o_wdata_ack1 = ack1_q;
  assign o_ram_wr     = ram_wr_q;
  assign ov_ram_wdata = wdata_q;
  assign ov_ram_waddr = waddr_q;
  assign ov_grant     = 2'(state_q);

`ifdef PKT_RAM_WR_ARB_DEBUG_EN
  logic [DBG_CNT_W-1:0] pkt_cnt0_q;
  logic [DBG_CNT_W-1:0] pkt_cnt1_q;

  // Count tail words as they are written (and acked); wraps at 0xFFFF.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else if (wr_c && tail_c) begin
      if (sel_c) begin
        pkt_cnt1_q <= pkt_cnt1_q + DBG_CNT_W'(1);
      end else begin
        pkt_cnt0_q <= pkt_cnt0_q + DBG_CNT_W'(1);
      end
    end
  end

  assign ov_debug_pkt_cnt0 = pkt_cnt0_q;
  assign ov_debug_pkt_cnt1 = pkt_cnt1_q;
`else
  assign ov_debug_pkt_cnt0 = '0;
  assign ov_debug_pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_pkt_ram_write_arbiter.sv
// Self-checking bench for pkt_ram_write_arbiter: two requester models drive
// packets; a cycle-level reference of the arbitration rules predicts outputs.
module tb_pkt_ram_write_arbiter;

  localparam int TMO = 8;

  typedef struct {
    logic [133:0] d;
    logic [15:0]  a;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr [2];
  logic [133:0] wd [2];
  logic [15:0]  wa [2];
  logic         ack0, ack1, ram_wr, to_pulse;
  logic [133:0] ram_wd;
  logic [15:0]  ram_wa;
  logic [1:0]   grant;
  logic [15:0]  cnt0, cnt1;

  pkt_ram_write_arbiter #(.DATA_W(134), .ADDR_W(16), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr0(wr[0]), .iv_wdata0(wd[0]), .iv_waddr0(wa[0]), .o_wdata_ack0(ack0),
    .i_wr1(wr[1]), .iv_wdata1(wd[1]), .iv_waddr1(wa[1]), .o_wdata_ack1(ack1),
    .o_ram_wr(ram_wr), .ov_ram_wdata(ram_wd), .ov_ram_waddr(ram_wa),
    .ov_grant(grant), .o_lock_timeout(to_pulse),
    .ov_debug_pkt_cnt0(cnt0), .ov_debug_pkt_cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // requester state
  word_t       q0[$], q1[$];
  logic        hold [2];
  int unsigned go_pct = 100;
  int          wlog[$];
  int          n_ack [2];
  int          words_pushed = 0;

  // reference model state
  int           m_owner, m_rr, m_idle;
  logic         m_ack [2];
  logic         m_wr, m_to;
  logic [133:0] m_wd;
  logic [15:0]  m_wa;
  logic [15:0]  m_cnt [2];

  function automatic logic [133:0] rnd_word(input logic [1:0] tag);
    logic [133:0] w;
    w[31:0]    = $urandom;
    w[63:32]   = $urandom;
    w[95:64]   = $urandom;
    w[127:96]  = $urandom;
    w[131:128] = 4'($urandom);
    w[133:132] = tag;
    return w;
  endfunction

  task automatic push_pkt(input int p, input int len, input logic [15:0] base);
    word_t w;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) w.d = rnd_word(2'b10);
      else if (i == 0)  w.d = rnd_word(2'b01);
      else              w.d = rnd_word(2'b11);
      w.a = base + 16'(i);
      if (p == 0) q0.push_back(w); else q1.push_back(w);
      words_pushed++;
    end
  endtask

  task automatic present(input int p);
    word_t w;
    if (p == 0 && q0.size() > 0 && $urandom_range(0, 99) < go_pct) begin
      w = q0[0]; wr[0] = 1'b1; wd[0] = w.d; wa[0] = w.a;
    end else if (p == 1 && q1.size() > 0 && $urandom_range(0, 99) < go_pct) begin
      w = q1[0]; wr[1] = 1'b1; wd[1] = w.d; wa[1] = w.a;
    end else begin
      wr[p] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      wr[p] = 1'b0; wd[p] = '0; wa[p] = '0; hold[p] = 1'b0;
      m_ack[p] = 1'b0; m_cnt[p] = '0; n_ack[p] = 0;
    end
    q0.delete(); q1.delete(); wlog.delete();
    m_owner = -1; m_rr = 0; m_idle = 0; m_wr = 1'b0; m_to = 1'b0;
    m_wd = '0; m_wa = '0; go_pct = 100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: predict, advance, compare, then let requesters react.
  task automatic step();
    logic e0, e1, w, tail;
    int k;
    logic [133:0] d;
    logic [15:0]  a;
    logic [1:0]   eg;
    e0 = wr[0] && !m_ack[0];
    e1 = wr[1] && !m_ack[1];
    w = 1'b0; m_to = 1'b0;
    if (m_owner < 0) begin
      w = e0 || e1;
      k = (e0 && e1) ? m_rr : (e1 ? 1 : 0);
    end else begin
      k = m_owner;
      w = (k == 0) ? e0 : e1;
    end
    d = wd[k]; a = wa[k];
    tail = w && (d[133:132] == 2'b10);
    if (w) begin
      m_wd = d; m_wa = a; m_idle = 0;
      if (tail) begin
        m_owner = -1; m_rr = 1 - k; m_cnt[k] = m_cnt[k] + 16'd1;
      end else begin
        m_owner = k;
      end
    end else if (m_owner >= 0) begin
      if (m_idle + 1 == TMO) begin
        m_owner = -1; m_rr = 1 - k; m_to = 1'b1; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    m_ack[0] = w && (k == 0);
    m_ack[1] = w && (k == 1);
    m_wr = w;
    eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);

    @(posedge clk); #1;

    n_vec++; if (ram_wr !== m_wr) begin n_err++; $display("FAIL ram_wr t=%0t got %b want %b", $time, ram_wr, m_wr); end
    n_vec++; if (ack0 !== m_ack[0]) begin n_err++; $display("FAIL ack0 t=%0t got %b want %b", $time, ack0, m_ack[0]); end
    n_vec++; if (ack1 !== m_ack[1]) begin n_err++; $display("FAIL ack1 t=%0t got %b want %b", $time, ack1, m_ack[1]); end
    n_vec++; if (grant !== eg) begin n_err++; $display("FAIL grant t=%0t got %b want %b", $time, grant, eg); end
    n_vec++; if (to_pulse !== m_to) begin n_err++; $display("FAIL lock_timeout t=%0t got %b want %b", $time, to_pulse, m_to); end
    n_vec++; if (ram_wd !== m_wd) begin n_err++; $display("FAIL ram_wdata t=%0t got %h want %h", $time, ram_wd, m_wd); end
    n_vec++; if (ram_wa !== m_wa) begin n_err++; $display("FAIL ram_waddr t=%0t got %h want %h", $time, ram_wa, m_wa); end
`ifdef PKT_RAM_WR_ARB_DEBUG_EN
    n_vec++; if (cnt0 !== m_cnt[0]) begin n_err++; $display("FAIL pkt_cnt0 t=%0t got %0d want %0d", $time, cnt0, m_cnt[0]); end
    n_vec++; if (cnt1 !== m_cnt[1]) begin n_err++; $display("FAIL pkt_cnt1 t=%0t got %0d want %0d", $time, cnt1, m_cnt[1]); end
`else
    n_vec++; if ({cnt0, cnt1} !== 32'd0) begin n_err++; $display("FAIL pkt_cnt_tied t=%0t got %h want 0", $time, {cnt0, cnt1}); end
`endif

    if (ram_wr) wlog.push_back(ack1 ? 1 : 0);
    if (ack0) n_ack[0]++;
    if (ack1) n_ack[1]++;

    for (int p = 0; p < 2; p++) begin
      if ((p == 0) ? ack0 : ack1) begin
        if (p == 0 && q0.size() > 0) void'(q0.pop_front());
        if (p == 1 && q1.size() > 0) void'(q1.pop_front());
        hold[p] = 1'b1;
      end else if (hold[p] || !wr[p]) begin
        hold[p] = 1'b0;
        present(p);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || wr[0] || wr[1] || hold[0] || hold[1] || m_owner >= 0)
           && n < budget) begin
      step();
      n++;
    end
    step(); step();
    n_vec++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL drain budget %0d cycles used up, q0=%0d q1=%0d left", budget, q0.size(), q1.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++; if ({ram_wr, ack0, ack1, grant, to_pulse} !== 6'd0) begin n_err++; $display("FAIL %s ctrl got %b want 0", tag, {ram_wr, ack0, ack1, grant, to_pulse}); end
    n_vec++; if (ram_wd !== 134'd0) begin n_err++; $display("FAIL %s wdata got %h want 0", tag, ram_wd); end
    n_vec++; if (ram_wa !== 16'd0) begin n_err++; $display("FAIL %s waddr got %h want 0", tag, ram_wa); end
    n_vec++; if ({cnt0, cnt1} !== 32'd0) begin n_err++; $display("FAIL %s dbg cnt got %h want 0", tag, {cnt0, cnt1}); end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_reset_outputs("reset");
  endtask

  task automatic test_single_port();
    int sum;
    do_reset();
    push_pkt(0, 3, 16'h0100);
    drain(60);
    sum = 0;
    foreach (wlog[i]) sum += wlog[i];
    n_vec++; if (wlog.size() !== 3) begin n_err++; $display("FAIL single_port writes got %0d want 3", wlog.size()); end
    n_vec++; if (sum !== 0) begin n_err++; $display("FAIL single_port port1 writes got %0d want 0", sum); end
    // rr now points at port 1: simultaneous single-word packets go 1 then 0
    push_pkt(0, 1, 16'h0200);
    push_pkt(1, 1, 16'h0300);
    drain(60);
    n_vec++; if (wlog.size() !== 5 || wlog[3] !== 1) begin n_err++; $display("FAIL single_port rr got size %0d want port1 first", wlog.size()); end
  endtask

  task automatic test_both_ports();
    int exp_seq [4] = '{0, 0, 1, 1};
    do_reset();
    push_pkt(0, 2, 16'h1000);
    push_pkt(1, 2, 16'h2000);
    drain(60);
    n_vec++; if (wlog.size() !== 4) begin n_err++; $display("FAIL both_ports writes got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      n_vec++; if (wlog[i] !== exp_seq[i]) begin n_err++; $display("FAIL both_ports order[%0d] got %0d want %0d", i, wlog[i], exp_seq[i]); end
    end
`ifdef PKT_RAM_WR_ARB_DEBUG_EN
    n_vec++; if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin n_err++; $display("FAIL both_ports cnt got %0d/%0d want 1/1", cnt0, cnt1); end
`endif
  endtask

  task automatic test_lock_hold();
    int exp_seq [6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    push_pkt(0, 4, 16'h0400);
    repeat (3) step();
    push_pkt(1, 2, 16'h0500);
    drain(80);
    n_vec++; if (wlog.size() !== 6) begin n_err++; $display("FAIL lock_hold writes got %0d want 6", wlog.size()); end
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      n_vec++; if (wlog[i] !== exp_seq[i]) begin n_err++; $display("FAIL lock_hold order[%0d] got %0d want %0d", i, wlog[i], exp_seq[i]); end
    end
  endtask

  task automatic test_ack_hold();
    do_reset();
    push_pkt(0, 5, 16'h0600);
    drain(80);
    n_vec++; if (wlog.size() !== 5) begin n_err++; $display("FAIL ack_hold writes got %0d want 5", wlog.size()); end
    n_vec++; if (n_ack[0] !== 5 || n_ack[1] !== 0) begin n_err++; $display("FAIL ack_hold acks got %0d/%0d want 5/0", n_ack[0], n_ack[1]); end
  endtask

  task automatic test_timeout();
    word_t w;
    int t_head, t_to;
    do_reset();
    w.d = rnd_word(2'b01); w.a = 16'h0700;
    q0.push_back(w);
    push_pkt(1, 2, 16'h0800);
    t_head = -1; t_to = -1;
    for (int c = 0; c < 40 && t_to < 0; c++) begin
      step();
      if (ram_wr && t_head < 0) t_head = c;
      if (to_pulse) t_to = c;
    end
    n_vec++; if (t_to < 0 || t_head < 0 || (t_to - t_head) !== TMO) begin n_err++; $display("FAIL timeout delay got %0d want %0d", t_to - t_head, TMO); end
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL timeout grant got %b want 00", grant); end
    drain(60);
    n_vec++; if (wlog.size() !== 3 || wlog[0] !== 0 || wlog[1] !== 1 || wlog[2] !== 1) begin n_err++; $display("FAIL timeout order got size %0d want 0,1,1", wlog.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    push_pkt(1, 3, 16'h0900);
    n = 0;
    while (wlog.size() < 2 && n < 30) begin step(); n++; end
    n_vec++; if (grant !== 2'b10) begin n_err++; $display("FAIL reset_mid pre grant got %b want 10", grant); end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    do_reset();
    push_pkt(0, 1, 16'h0a00);
    push_pkt(1, 1, 16'h0b00);
    drain(60);
    n_vec++; if (wlog.size() !== 2 || wlog[0] !== 0) begin n_err++; $display("FAIL reset_mid rr got size %0d want port0 first", wlog.size()); end
  endtask

  task automatic test_random();
    do_reset();
    words_pushed = 0;
    for (int r = 0; r < 4; r++) begin
      go_pct = $urandom_range(55, 100);
      for (int i = 0; i < 10; i++)
        push_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)), 16'($urandom));
      drain(2000);
    end
    n_vec++; if (wlog.size() !== words_pushed) begin n_err++; $display("FAIL random writes got %0d want %0d", wlog.size(), words_pushed); end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_both_ports();
    test_lock_hold();
    test_ack_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

endmodule
